mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency memory between the processor's instruction port (requester 0) and data port (requester 1).
- Arbitrates per cycle with val/rdy on the request side and routes each response back to its owner exactly one cycle later.
- Sits between Proc and a unified memory, so the core can run against a single-port RAM instead of the dual-port TestMemory.
- Keeps a saturating conflict counter for performance tracing.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   MEMREQ_READ / MEMREQ_WRITE : memory request type encodings
//   ARB_FIXED / ARB_RR         : arbitration mode selectors
//   memreq_t                   : one memory request (type, address, write data)
package mem_arb_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memreq_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two processor ports, the arbiter and the memory.
//   req0_* / req1_*  : val/rdy request channels (instruction / data port)
//   resp0_* / resp1_*: response channels, no backpressure
//   mem_req_*        : request towards the single-ported memory
//   mem_resp_data    : memory read data, valid the cycle after mem_req_val
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if;

  logic        req0_val;
  logic        req0_rdy;
  logic        req0_type;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;

  logic        req1_val;
  logic        req1_rdy;
  logic        req1_type;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;

  logic        resp0_val;
  logic [31:0] resp0_data;
  logic        resp1_val;
  logic [31:0] resp1_data;

  logic        mem_req_val;
  logic        mem_req_type;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [31:0] mem_resp_data;

  modport slave (
    input  req0_val, req0_type, req0_addr, req0_wdata,
    input  req1_val, req1_type, req1_addr, req1_wdata,
    input  mem_resp_data,
    output req0_rdy, req1_rdy,
    output resp0_val, resp0_data, resp1_val, resp1_data,
    output mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata
  );

  modport master (
    output req0_val, req0_type, req0_addr, req0_wdata,
    output req1_val, req1_type, req1_addr, req1_wdata,
    output mem_resp_data,
    input  req0_rdy, req1_rdy,
    input  resp0_val, resp0_data, resp1_val, resp1_data,
    input  mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter, fixed-priority or round-robin.
//   clk, rst : clock, asynchronous active-low reset
//   mode     : ARB_FIXED (requester 1 wins conflicts) or ARB_RR
//   val      : request valids, bit i = requester i
//   xfer     : a grant was taken this cycle (advances the round-robin pointer)
//   gnt      : one-hot grant, all zero when idle or in reset
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [1:0] val,
  input  logic       xfer,
  output logic [1:0] gnt
);

  // Index of the requester that wins the next round-robin conflict.
  logic prio_q, prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (rst) begin
      if (val == 2'b11) begin
        if (mode == ARB_FIXED || prio_q) gnt = 2'b10;
        else                             gnt = 2'b01;
      end else begin
        gnt = val;
      end
    end
    // Favour whoever did not just win.
    if (xfer) prio_d = ~gnt[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency memory between the instruction
// port (requester 0) and the data port (requester 1).
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : request/response/memory signals (slave modport)
//   conflict_cnt : saturating count of cycles with both requesters valid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic        ARB_MODE = ARB_RR,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic [1:0]       val, gnt;
  logic             xfer;
  memreq_t          req0, req1, req_sel;
  logic             pend_q, pend_d;
  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata;

  assign val = {bus.req1_val, bus.req0_val};

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .mode (ARB_MODE),
    .val  (val),
    .xfer (xfer),
    .gnt  (gnt)
  );

  assign xfer = |gnt;

  assign req0 = '{typ: bus.req0_type, addr: bus.req0_addr, wdata: bus.req0_wdata};
  assign req1 = '{typ: bus.req1_type, addr: bus.req1_addr, wdata: bus.req1_wdata};

  always_comb begin
    req_sel = '0;
    if (gnt[1])      req_sel = req1;
    else if (gnt[0]) req_sel = req0;
  end

  assign bus.req0_rdy      = gnt[0];
  assign bus.req1_rdy      = gnt[1];
  assign bus.mem_req_val   = xfer;
  assign bus.mem_req_type  = req_sel.typ;
  assign bus.mem_req_addr  = req_sel.addr;
  assign bus.mem_req_wdata = req_sel.wdata;

  // Response pipeline: remember who was granted and whether it was a write.
  assign pend_d  = xfer;
  assign owner_d = gnt[1];
  assign wr_d    = req_sel.typ;

  always_comb begin
    cnt_d = cnt_q;
    if (&val && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      wr_q    <= MEMREQ_READ;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write acks carry zero data regardless of what the memory drives.
  assign rdata = (pend_q && wr_q == MEMREQ_READ) ? bus.mem_resp_data : 32'h0;

  assign bus.resp0_val  = pend_q & ~owner_q;
  assign bus.resp1_val  = pend_q &  owner_q;
  assign bus.resp0_data = bus.resp0_val ? rdata : 32'h0;
  assign bus.resp1_data = bus.resp1_val ? rdata : 32'h0;

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one round-robin instance with a memory model, one
// fixed-priority instance and one with a 4-bit conflict counter.
module tb_mem_port_arbiter;

  localparam logic [31:0] DI = 32'h0050_0093;
  localparam logic [31:0] DM = 32'h1111_1111;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if if_rr();
  mem_port_arbiter_if if_fx();
  mem_port_arbiter_if if_c4();

  logic [15:0] cnt_rr, cnt_fx;
  logic [3:0]  cnt_c4;

  mem_port_arbiter #(.ARB_MODE(1'b1), .CNT_W(16)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave), .conflict_cnt(cnt_rr));
  mem_port_arbiter #(.ARB_MODE(1'b0), .CNT_W(16)) u_fx (.clk(clk), .rst(rst), .bus(if_fx.slave), .conflict_cnt(cnt_fx));
  mem_port_arbiter #(.ARB_MODE(1'b1), .CNT_W(4))  u_c4 (.clk(clk), .rst(rst), .bus(if_c4.slave), .conflict_cnt(cnt_c4));

  logic        r0v, r0t, r1v, r1t;
  logic [31:0] r0a, r0w, r1a, r1w;

  assign if_rr.req0_val = r0v; assign if_rr.req0_type = r0t; assign if_rr.req0_addr = r0a; assign if_rr.req0_wdata = r0w;
  assign if_rr.req1_val = r1v; assign if_rr.req1_type = r1t; assign if_rr.req1_addr = r1a; assign if_rr.req1_wdata = r1w;
  assign if_fx.req0_val = r0v; assign if_fx.req0_type = r0t; assign if_fx.req0_addr = r0a; assign if_fx.req0_wdata = r0w;
  assign if_fx.req1_val = r1v; assign if_fx.req1_type = r1t; assign if_fx.req1_addr = r1a; assign if_fx.req1_wdata = r1w;
  assign if_c4.req0_val = r0v; assign if_c4.req0_type = r0t; assign if_c4.req0_addr = r0a; assign if_c4.req0_wdata = r0w;
  assign if_c4.req1_val = r1v; assign if_c4.req1_type = r1t; assign if_c4.req1_addr = r1a; assign if_c4.req1_wdata = r1w;
  assign if_fx.mem_resp_data = 32'h0;
  assign if_c4.mem_resp_data = 32'h0;

  // Single-ported memory, 1-cycle read latency; drives junk on writes.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (!rst) begin
      mem[12'h080] <= DI;
      mem[12'h800] <= DM;
    end else if (if_rr.mem_req_val) begin
      if (if_rr.mem_req_type) begin
        mem[if_rr.mem_req_addr[13:2]] <= if_rr.mem_req_wdata;
        if_rr.mem_resp_data <= 32'hBAD0_BAD0;
      end else begin
        if_rr.mem_resp_data <= mem[if_rr.mem_req_addr[13:2]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r0v, r0t; logic [31:0] r0a, r0w;
    logic        r1v, r1t; logic [31:0] r1a, r1w;
    logic        e0rdy, e1rdy, emv, emt; logic [31:0] ema, emw;
    logic        ev0; logic [31:0] ed0;
    logic        ev1; logic [31:0] ed1;
    logic [15:0] ecnt;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic drive(input logic a0v, input logic a0t, input logic [31:0] a0a, input logic [31:0] a0w,
                       input logic a1v, input logic a1t, input logic [31:0] a1a, input logic [31:0] a1w);
    r0v = a0v; r0t = a0t; r0a = a0a; r0w = a0w;
    r1v = a1v; r1t = a1t; r1a = a1a; r1w = a1w;
  endtask

  initial begin
    int exp_c4;
    int pulses;

    // inputs: r0 v,t,addr,wdata | r1 v,t,addr,wdata || expected: rdy0,rdy1,mval,mtype,maddr,mwdata | rv0,rd0 | rv1,rd1 | cnt
    vecs[0]  = '{1'b1,1'b0,32'h200,32'h0, 1'b1,1'b0,32'h2000,32'h0, 1'b1,1'b0,1'b1,1'b0,32'h200,32'h0,   1'b0,32'h0, 1'b0,32'h0, 16'd0};
    vecs[1]  = '{1'b1,1'b0,32'h200,32'h0, 1'b1,1'b0,32'h2000,32'h0, 1'b0,1'b1,1'b1,1'b0,32'h2000,32'h0,  1'b1,DI,    1'b0,32'h0, 16'd1};
    vecs[2]  = '{1'b1,1'b0,32'h200,32'h0, 1'b1,1'b0,32'h2000,32'h0, 1'b1,1'b0,1'b1,1'b0,32'h200,32'h0,   1'b0,32'h0, 1'b1,DM,    16'd2};
    vecs[3]  = '{1'b1,1'b0,32'h200,32'h0, 1'b1,1'b0,32'h2000,32'h0, 1'b0,1'b1,1'b1,1'b0,32'h2000,32'h0,  1'b1,DI,    1'b0,32'h0, 16'd3};
    vecs[4]  = '{1'b0,1'b1,32'h300,32'h5, 1'b0,1'b1,32'h3000,32'h6, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,     1'b0,32'h0, 1'b1,DM,    16'd4};
    vecs[5]  = '{1'b1,1'b0,32'h200,32'h0, 1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h200,32'h0,   1'b0,32'h0, 1'b0,32'h0, 16'd4};
    vecs[6]  = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,     1'b1,DI,    1'b0,32'h0, 16'd4};
    vecs[7]  = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b1,32'h2000,DB,    1'b0,1'b1,1'b1,1'b1,32'h2000,DB,     1'b0,32'h0, 1'b0,32'h0, 16'd4};
    vecs[8]  = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h2000,32'h0, 1'b0,1'b1,1'b1,1'b0,32'h2000,32'h0,  1'b0,32'h0, 1'b1,32'h0, 16'd4};
    vecs[9]  = '{1'b0,1'b1,32'h300,32'h5, 1'b0,1'b1,32'h3000,32'h6, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,     1'b0,32'h0, 1'b1,DB,    16'd4};
    vecs[10] = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h2000,32'h0, 1'b0,1'b1,1'b1,1'b0,32'h2000,32'h0,  1'b0,32'h0, 1'b0,32'h0, 16'd4};
    vecs[11] = '{1'b1,1'b0,32'h200,32'h0, 1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h200,32'h0,   1'b0,32'h0, 1'b1,DB,    16'd4};
    vecs[12] = '{1'b1,1'b0,32'h200,32'hCAFE0000, 1'b1,1'b0,32'h2000,32'hCAFE0001, 1'b0,1'b1,1'b1,1'b0,32'h2000,32'hCAFE0001, 1'b1,DI, 1'b0,32'h0, 16'd4};
    vecs[13] = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,     1'b0,32'h0, 1'b1,DB,    16'd5};

    // Reset: outputs forced low even with both requesters valid.
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_rdy0", {31'b0, if_rr.req0_rdy}, 32'd0);
    chk("rst_rdy1", {31'b0, if_rr.req1_rdy}, 32'd0);
    chk("rst_mval", {31'b0, if_rr.mem_req_val}, 32'd0);
    chk("rst_maddr", if_rr.mem_req_addr, 32'd0);
    chk("rst_resp", {30'b0, if_rr.resp1_val, if_rr.resp0_val}, 32'd0);
    chk("rst_cnt", {16'b0, cnt_rr}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].r0v, vecs[i].r0t, vecs[i].r0a, vecs[i].r0w, vecs[i].r1v, vecs[i].r1t, vecs[i].r1a, vecs[i].r1w);
      @(negedge clk);
      chk($sformatf("v%0d_rdy0", i),   {31'b0, if_rr.req0_rdy},     {31'b0, vecs[i].e0rdy});
      chk($sformatf("v%0d_rdy1", i),   {31'b0, if_rr.req1_rdy},     {31'b0, vecs[i].e1rdy});
      chk($sformatf("v%0d_mval", i),   {31'b0, if_rr.mem_req_val},  {31'b0, vecs[i].emv});
      chk($sformatf("v%0d_mtype", i),  {31'b0, if_rr.mem_req_type}, {31'b0, vecs[i].emt});
      chk($sformatf("v%0d_maddr", i),  if_rr.mem_req_addr,          vecs[i].ema);
      chk($sformatf("v%0d_mwdata", i), if_rr.mem_req_wdata,         vecs[i].emw);
      chk($sformatf("v%0d_rval0", i),  {31'b0, if_rr.resp0_val},    {31'b0, vecs[i].ev0});
      chk($sformatf("v%0d_rdata0", i), if_rr.resp0_data,            vecs[i].ed0);
      chk($sformatf("v%0d_rval1", i),  {31'b0, if_rr.resp1_val},    {31'b0, vecs[i].ev1});
      chk($sformatf("v%0d_rdata1", i), if_rr.resp1_data,            vecs[i].ed1);
      chk($sformatf("v%0d_cnt", i),    {16'b0, cnt_rr},             {16'b0, vecs[i].ecnt});
      @(posedge clk); #1;
    end

    // Reset in the cycle after a read grant drops the in-flight response.
    drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid_grant", {31'b0, if_rr.req0_rdy}, 32'd1);
    @(posedge clk); #1;
    chk("mid_inflight", {31'b0, if_rr.resp0_val}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rval0", {31'b0, if_rr.resp0_val}, 32'd0);
    chk("mid_rdata0", if_rr.resp0_data, 32'd0);
    chk("mid_rdy0", {31'b0, if_rr.req0_rdy}, 32'd0);
    chk("mid_mval", {31'b0, if_rr.mem_req_val}, 32'd0);
    chk("mid_cnt", {16'b0, cnt_rr}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("post_rst_resp", {30'b0, if_rr.resp1_val, if_rr.resp0_val}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_resp2", {30'b0, if_rr.resp1_val, if_rr.resp0_val}, 32'd0);

    // Fixed priority: requester 1 wins every conflict.
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      if (k < 3) begin
        chk($sformatf("fx%0d_rdy1", k), {31'b0, if_fx.req1_rdy}, 32'd1);
        chk($sformatf("fx%0d_rdy0", k), {31'b0, if_fx.req0_rdy}, 32'd0);
      end
      chk($sformatf("fx%0d_rval0", k), {31'b0, if_fx.resp0_val}, 32'd0);
      if (if_fx.resp1_val) pulses++;
      @(posedge clk); #1;
    end
    chk("fx_pulses", pulses, 32'd3);
    chk("fx_cnt", {16'b0, cnt_fx}, 32'd3);

    // 4-bit counter saturates at 15 (starts from the 3 conflicts above).
    exp_c4 = 3;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
      @(negedge clk);
      chk($sformatf("c4_cnt%0d", k), {28'b0, cnt_c4}, exp_c4);
      @(posedge clk); #1;
      if (exp_c4 < 15) exp_c4++;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("c4_sat", {28'b0, cnt_c4}, 32'd15);
    chk("rr_cnt_nosat", {16'b0, cnt_rr}, 32'd23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
